// File: rtl/apu_pkg.sv
// Shared APU frame-counter constants, $4017 bit positions and write-FSM state type.
package apu_pkg;

    localparam int STEP1   = 7457;
    localparam int STEP2   = 14913;
    localparam int STEP3   = 22371;
    localparam int STEP4   = 29829;
    localparam int PERIOD4 = 29830;
    localparam int STEP5   = 37281;
    localparam int PERIOD5 = 37282;

    localparam int MODE_BIT = 7;
    localparam int INH_BIT  = 6;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } wr_state_t;

endpackage

// File: rtl/frame_write_sync.sv
// Holds a $4017 mode write until its apply tick. Build option FRAME_WRITE_DELAY_EN
// moves the apply tick from the 1st to the 3rd cpu_ce after the write.
module frame_write_sync
    import apu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cpu_ce,
    input  logic wr_4017,
    input  logic mode_bit,
    output logic apply,
    output logic pend_mode
);

    wr_state_t state, state_nx;
    logic      dly_done;

`ifdef FRAME_WRITE_DELAY_EN
    logic [1:0] dly;

    assign dly_done = (dly == 2'd2);

    // Counts cpu_ce ticks spent in PENDING; a rewrite starts the count over.
    always_ff @(posedge clk) begin
        if (rst) begin
            dly <= 2'd0;
        end else if (wr_4017) begin
            dly <= 2'd0;
        end else if (state == PENDING && cpu_ce && !dly_done) begin
            dly <= dly + 2'd1;
        end
    end
`else
    assign dly_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_4017) begin
            pend_mode <= mode_bit;
        end
    end

    // A write on the same edge as cpu_ce never applies on that edge.
    always_comb begin
        state_nx = state;
        apply    = 1'b0;
        if (wr_4017) begin
            state_nx = PENDING;
        end else if (state == PENDING && cpu_ce && dly_done) begin
            apply    = 1'b1;
            state_nx = IDLE;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// APU frame counter: quarter/half-frame pulses, $4017 mode/inhibit and frame IRQ.
// Optional build macro FRAME_WRITE_DELAY_EN (see frame_write_sync) delays mode writes.
module frame_sequencer #(
    parameter int CNT_W   = 16,
    parameter int STEP1   = apu_pkg::STEP1,
    parameter int STEP2   = apu_pkg::STEP2,
    parameter int STEP3   = apu_pkg::STEP3,
    parameter int STEP4   = apu_pkg::STEP4,
    parameter int PERIOD4 = apu_pkg::PERIOD4,
    parameter int STEP5   = apu_pkg::STEP5,
    parameter int PERIOD5 = apu_pkg::PERIOD5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpu_ce,
    input  logic       wr_4017,
    input  logic [7:0] din,
    input  logic       rd_4015,
    output logic       quarter_clk,
    output logic       half_clk,
    output logic       irq,
    output logic       mode_o,
    output logic [2:0] step_o
);

    if (PERIOD4 > (1 << CNT_W) - 1 || PERIOD5 > (1 << CNT_W) - 1) begin : g_bad_cnt_w
        $error("frame_sequencer: frame periods do not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] S1 = CNT_W'(STEP1);
    localparam logic [CNT_W-1:0] S2 = CNT_W'(STEP2);
    localparam logic [CNT_W-1:0] S3 = CNT_W'(STEP3);
    localparam logic [CNT_W-1:0] S4 = CNT_W'(STEP4);
    localparam logic [CNT_W-1:0] S5 = CNT_W'(STEP5);
    localparam logic [CNT_W-1:0] P4 = CNT_W'(PERIOD4);
    localparam logic [CNT_W-1:0] P5 = CNT_W'(PERIOD5);

    logic [CNT_W-1:0] cnt, cnt_inc, cnt_nx;
    logic             mode, inhibit, apply, pend_mode;
    logic [2:0]       step;
    logic             wrap, ev_quarter, ev_half, irq_set;
    logic             unused_din;

    assign unused_din = ^din[5:0];

    frame_write_sync u_wsync (
        .clk       (clk),
        .rst       (rst),
        .cpu_ce    (cpu_ce),
        .wr_4017   (wr_4017),
        .mode_bit  (din[apu_pkg::MODE_BIT]),
        .apply     (apply),
        .pend_mode (pend_mode)
    );

    // Decode runs on the post-increment value so the pulse lands on the same edge.
    always_comb begin
        cnt_inc    = cnt + CNT_W'(1);
        wrap       = (cnt_inc == (mode ? P5 : P4));
        cnt_nx     = wrap ? '0 : cnt_inc;
        ev_half    = (cnt_nx == S2) || (cnt_nx == (mode ? S5 : S4));
        ev_quarter = ev_half || (cnt_nx == S1) || (cnt_nx == S3);
        irq_set    = cpu_ce && !apply && !mode && !inhibit &&
                     ((cnt_nx == P4 - CNT_W'(2)) || (cnt_nx == P4 - CNT_W'(1)) || wrap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            mode        <= 1'b0;
            inhibit     <= 1'b0;
            irq         <= 1'b0;
            quarter_clk <= 1'b0;
            half_clk    <= 1'b0;
            step        <= 3'd0;
        end else begin
            quarter_clk <= 1'b0;
            half_clk    <= 1'b0;
            if (cpu_ce) begin
                if (apply) begin
                    cnt         <= '0;
                    mode        <= pend_mode;
                    step        <= 3'd0;
                    quarter_clk <= pend_mode;
                    half_clk    <= pend_mode;
                end else begin
                    cnt         <= cnt_nx;
                    quarter_clk <= ev_quarter;
                    half_clk    <= ev_half;
                    if (wrap) begin
                        step <= 3'd0;
                    end else if (ev_quarter) begin
                        step <= step + 3'd1;
                    end
                end
            end
            // Set beats a read-clear; an inhibiting write beats both.
            if (irq_set) begin
                irq <= 1'b1;
            end else if (rd_4015) begin
                irq <= 1'b0;
            end
            if (wr_4017) begin
                inhibit <= din[apu_pkg::INH_BIT];
                if (din[apu_pkg::INH_BIT]) begin
                    irq <= 1'b0;
                end
            end
        end
    end

    assign mode_o = mode;
    assign step_o = step;

endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer using a shortened frame schedule.
module tb_frame_sequencer;

    localparam int CW = 10;
    localparam int S1 = 117;
    localparam int S2 = 233;
    localparam int S3 = 350;
    localparam int S4 = 466;
    localparam int P4 = 467;
    localparam int S5 = 583;
    localparam int P5 = 584;
`ifdef FRAME_WRITE_DELAY_EN
    localparam int APPLY_N = 3;
`else
    localparam int APPLY_N = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_ce = 1'b0;
    logic       wr_4017 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd_4015 = 1'b0;
    logic       quarter_clk, half_clk, irq, mode_o;
    logic [2:0] step_o;

    frame_sequencer #(
        .CNT_W(CW), .STEP1(S1), .STEP2(S2), .STEP3(S3), .STEP4(S4),
        .PERIOD4(P4), .STEP5(S5), .PERIOD5(P5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce      (cpu_ce),
        .wr_4017     (wr_4017),
        .din         (din),
        .rd_4015     (rd_4015),
        .quarter_clk (quarter_clk),
        .half_clk    (half_clk),
        .irq         (irq),
        .mode_o      (mode_o),
        .step_o      (step_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       q;
        logic       h;
        logic       irq;
        logic       mode;
        logic [2:0] step;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: frame position, active mode, inhibit, irq and a pending write.
    int   m_pos = 0;
    logic m_mode = 1'b0;
    logic m_inh = 1'b0;
    logic m_irq = 1'b0;
    logic m_pend = 1'b0;
    logic m_pmode = 1'b0;
    int   m_left = 0;

    function automatic int final_tick(input logic md);
        return md ? S5 : S4;
    endfunction

    function automatic logic is_half(input logic md, input int p);
        return (p == S2) || (p == final_tick(md));
    endfunction

    function automatic logic is_quarter(input logic md, input int p);
        return (p == S1) || (p == S3) || is_half(md, p);
    endfunction

    function automatic logic [2:0] quarters_done(input logic md, input int p);
        int ticks[4];
        int n;
        ticks = '{S1, S2, S3, final_tick(md)};
        n = 0;
        foreach (ticks[i]) if (p >= ticks[i]) n++;
        return 3'(n);
    endfunction

    task automatic cycle(input logic r, input logic ce, input logic wr,
                         input logic [7:0] d, input logic rd);
        exp_t e;
        logic set_irq, applied, wrapped;
        rst = r; cpu_ce = ce; wr_4017 = wr; din = d; rd_4015 = rd;
        e = '0;
        set_irq = 1'b0; applied = 1'b0; wrapped = 1'b0;
        if (r) begin
            m_pos = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0; m_pend = 1'b0;
        end else begin
            if (ce && m_pend && !wr) begin
                m_left--;
                applied = (m_left == 0);
            end
            if (applied) begin
                m_pend = 1'b0;
                m_pos = 0;
                m_mode = m_pmode;
                e.q = m_pmode;
                e.h = m_pmode;
            end else if (ce) begin
                m_pos++;
                if (m_pos == (m_mode ? P5 : P4)) begin
                    m_pos = 0;
                    wrapped = 1'b1;
                end
                set_irq = !m_mode && !m_inh && (m_pos == P4 - 2 || m_pos == P4 - 1 || wrapped);
                e.q = is_quarter(m_mode, m_pos);
                e.h = is_half(m_mode, m_pos);
            end
            if (set_irq) m_irq = 1'b1;
            else if (rd) m_irq = 1'b0;
            if (wr) begin
                m_inh = d[6];
                if (d[6]) m_irq = 1'b0;
                m_pend = 1'b1;
                m_pmode = d[7];
                m_left = APPLY_N;
            end
        end
        e.irq = m_irq;
        e.mode = m_mode;
        e.step = quarters_done(m_mode, m_pos);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (m_pos != target && guard < 2 * P5) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            guard++;
        end
    endtask

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("quarter_clk", {2'b00, quarter_clk}, {2'b00, e.q});
                check("half_clk", {2'b00, half_clk}, {2'b00, e.h});
                check("irq", {2'b00, irq}, {2'b00, e.irq});
                check("mode_o", {2'b00, mode_o}, {2'b00, e.mode});
                check("step_o", step_o, e.step);
            end
        end
    end

    initial begin : driver
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // 4-step frame; read on the v=P4-1 tick (set wins), then at v=100.
        run_to(P4 - 2);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        run(1);
        run_to(99);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

        // Inhibit write coincident with an irq set tick, then three quiet frames.
        run_to(P4 - 2);
        cycle(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
        run(3 * P4 + 5);

        // Back to 4-step uninhibited, then switch to 5-step with a write off cpu_ce.
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        run(10);
        cycle(1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
        run(P5 + 20);

        // Rewrite after the first cpu_ce of a pending write.
        cycle(1'b0, 1'b1, 1'b1, 8'h80, 1'b0);
        run(1);
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        run(10);

        // Reset mid-frame with a write pending.
        run_to(200);
        cycle(1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        run(S1 + 5);

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            logic r, ce, wr, rd;
            r  = ($urandom_range(0, 3999) == 0);
            ce = ($urandom_range(0, 9) < 7);
            wr = ($urandom_range(0, 299) == 0);
            rd = ($urandom_range(0, 49) == 0);
            cycle(r, ce, wr, 8'($urandom_range(0, 255)), rd);
        end

        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
